// File: rtl/frog_move_sequencer.sv
// Frog sprite game controller: turns direction buttons into tile steps with hold-to-repeat
// and runs the PLAY / DYING / WON / OVER life cycle for the sprite renderer.
module frog_move_sequencer #(
  parameter int unsigned TILE_SIZE      = 32,
  parameter int unsigned H_VISIBLE_AREA = 640,
  parameter int unsigned V_VISIBLE_AREA = 480,
  parameter int unsigned START_X        = 320,
  parameter int unsigned START_Y        = 448,
  parameter int unsigned REPEAT_FRAMES  = 15,
  parameter int unsigned DEATH_FRAMES   = 60,
  parameter int unsigned WIN_FRAMES     = 60,
  parameter int unsigned START_LIVES    = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Frame_Tick,
  input  logic       i_Frog_Up,
  input  logic       i_Frog_Dn,
  input  logic       i_Frog_Lt,
  input  logic       i_Frog_Rt,
  input  logic       i_Hit,
  input  logic       i_Start,
  output logic [9:0] o_Frog_X,
  output logic [9:0] o_Frog_Y,
  output logic       o_Draw_Frog,
  output logic [1:0] o_State,
  output logic [2:0] o_Lives,
  output logic       o_Win
);

  localparam int unsigned POS_W     = 10;
  localparam int unsigned EXT_W     = 12;
  localparam int unsigned LIFE_W    = 3;
  localparam int unsigned REP_W     = $clog2(REPEAT_FRAMES + 1);
  localparam int unsigned TMR_MAX   = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES : WIN_FRAMES;
  localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);
  localparam int unsigned BLINK_BIT = 3;

  localparam logic [POS_W-1:0]  X0        = POS_W'(START_X);
  localparam logic [POS_W-1:0]  Y0        = POS_W'(START_Y);
  localparam logic [POS_W-1:0]  STEP      = POS_W'(TILE_SIZE);
  localparam logic [LIFE_W-1:0] LIVES0    = LIFE_W'(START_LIVES);
  localparam logic [REP_W-1:0]  REP_LOAD  = REP_W'(REPEAT_FRAMES - 1);
  localparam logic [TMR_W-1:0]  DEATH_LD  = TMR_W'(DEATH_FRAMES);
  localparam logic [TMR_W-1:0]  WIN_LD    = TMR_W'(WIN_FRAMES);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_DYING = 2'd1,
    S_WON   = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    D_NONE = 3'd0,
    D_UP   = 3'd1,
    D_DN   = 3'd2,
    D_LT   = 3'd3,
    D_RT   = 3'd4
  } dir_t;

  state_t             state_q, state_d;
  dir_t               dir_q, dir_d, dir_c;
  logic [POS_W-1:0]   x_q, x_d, y_q, y_d;
  logic [POS_W-1:0]   step_x_c, step_y_c;
  logic               step_ok_c;
  logic [LIFE_W-1:0]  lives_q, lives_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               draw_q, draw_d;
  logic               win_q, win_d;
  logic               do_step;

  // One-hot button decode; any other combination means no direction
  always_comb begin
    dir_c = D_NONE;
    case ({i_Frog_Up, i_Frog_Dn, i_Frog_Lt, i_Frog_Rt})
      4'b1000: dir_c = D_UP;
      4'b0100: dir_c = D_DN;
      4'b0010: dir_c = D_LT;
      4'b0001: dir_c = D_RT;
      default: dir_c = D_NONE;
    endcase
  end

  // Candidate step target and whether it stays fully on screen
  always_comb begin
    step_x_c  = x_q;
    step_y_c  = y_q;
    step_ok_c = 1'b0;
    case (dir_c)
      D_UP: begin
        step_ok_c = EXT_W'(y_q) >= EXT_W'(TILE_SIZE);
        step_y_c  = y_q - STEP;
      end
      D_DN: begin
        step_ok_c = (EXT_W'(y_q) + EXT_W'(2 * TILE_SIZE)) <= EXT_W'(V_VISIBLE_AREA);
        step_y_c  = y_q + STEP;
      end
      D_LT: begin
        step_ok_c = EXT_W'(x_q) >= EXT_W'(TILE_SIZE);
        step_x_c  = x_q - STEP;
      end
      D_RT: begin
        step_ok_c = (EXT_W'(x_q) + EXT_W'(2 * TILE_SIZE)) <= EXT_W'(H_VISIBLE_AREA);
        step_x_c  = x_q + STEP;
      end
      default: ;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    lives_d = lives_q;
    rep_d   = rep_q;
    tmr_d   = tmr_q;
    draw_d  = draw_q;
    win_d   = 1'b0;
    do_step = 1'b0;

    case (state_q)
      S_PLAY: begin
        if (i_Frame_Tick) begin
          if (i_Hit) begin
            lives_d = lives_q - LIFE_W'(1);
            rep_d   = '0;
            dir_d   = D_NONE;
            if (lives_q == LIFE_W'(1)) begin
              state_d = S_OVER;
              draw_d  = 1'b0;
            end else begin
              state_d = S_DYING;
              tmr_d   = DEATH_LD;
              draw_d  = DEATH_LD[BLINK_BIT];
            end
          end else begin
            dir_d = dir_c;
            if (dir_c == D_NONE) begin
              rep_d = '0;
            end else if ((dir_c != dir_q) || (rep_q == '0)) begin
              do_step = step_ok_c;
            end else begin
              rep_d = rep_q - REP_W'(1);
            end
            // Blocked attempts leave both position and repeat timing alone
            if (do_step) begin
              x_d   = step_x_c;
              y_d   = step_y_c;
              rep_d = REP_LOAD;
              if ((dir_c == D_UP) && (step_y_c == '0)) begin
                state_d = S_WON;
                win_d   = 1'b1;
                tmr_d   = WIN_LD;
              end
            end
          end
        end
      end

      S_DYING, S_WON: begin
        if (i_Frame_Tick) begin
          if (tmr_q <= TMR_W'(1)) begin
            state_d = S_PLAY;
            x_d     = X0;
            y_d     = Y0;
            rep_d   = '0;
            dir_d   = D_NONE;
            tmr_d   = '0;
            draw_d  = 1'b1;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
            if (state_q == S_DYING) begin
              draw_d = tmr_d[BLINK_BIT];
            end
          end
        end
      end

      S_OVER: begin
        if (i_Start) begin
          state_d = S_PLAY;
          x_d     = X0;
          y_d     = Y0;
          lives_d = LIVES0;
          rep_d   = '0;
          dir_d   = D_NONE;
          tmr_d   = '0;
          draw_d  = 1'b1;
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= S_PLAY;
      dir_q   <= D_NONE;
      x_q     <= X0;
      y_q     <= Y0;
      lives_q <= LIVES0;
      rep_q   <= '0;
      tmr_q   <= '0;
      draw_q  <= 1'b1;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lives_q <= lives_d;
      rep_q   <= rep_d;
      tmr_q   <= tmr_d;
      draw_q  <= draw_d;
      win_q   <= win_d;
    end
  end

  assign o_Frog_X    = x_q;
  assign o_Frog_Y    = y_q;
  assign o_Draw_Frog = draw_q;
  assign o_State     = state_q;
  assign o_Lives     = lives_q;
  assign o_Win       = win_q;

endmodule
